// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with delayed sync/blank and colour gating
// Coordinates go out undelayed for fetch; sync, blank and colour come out PIPE enabled cycles later.

module vga_timing_gen #(
  parameter int CDW      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE     = 2,
  parameter int CW       = 11
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             pix_en_i,
  output logic [CW-1:0]    x_o,
  output logic [CW-1:0]    y_o,
  output logic             fetch_de_o,
  input  logic [3*CDW-1:0] rgb_i,
  output logic [CDW-1:0]   vga_red_o,
  output logic [CDW-1:0]   vga_green_o,
  output logic [CDW-1:0]   vga_blue_o,
  output logic             horiz_sync,
  output logic             vert_sync,
  output logic             blank_o,
  output logic             sof_o,
  output logic             eol_o
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  generate
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_chk
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIPE < 1 || PIPE > 8) begin : g_pipe_chk
      $error("vga_timing_gen: PIPE must be in 1..8");
    end
  endgenerate

  // run_q distinguishes "just out of reset" from "showing x=0,y=0", so the first
  // enabled cycle presents the origin instead of stepping past it.
  logic            run_q, run_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic            de_q, de_d, sof_q, sof_d, eol_q, eol_d;
  logic [PIPE-1:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, de_pipe_q, de_pipe_d;
  logic [CDW-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic            hs_raw, vs_raw;

  always_comb begin
    hs_raw    = (32'(x_q) >= HS_START) && (32'(x_q) < HS_STOP);
    vs_raw    = (32'(y_q) >= VS_START) && (32'(y_q) < VS_STOP);
    run_d     = run_q;
    x_d       = x_q;
    y_d       = y_q;
    de_d      = de_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    hs_pipe_d = hs_pipe_q;
    vs_pipe_d = vs_pipe_q;
    de_pipe_d = de_pipe_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    if (pix_en_i) begin
      run_d = 1'b1;
      if (!run_q) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      de_d  = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
      sof_d = (x_d == '0) && (y_d == '0);
      eol_d = (x_d == H_LAST);
      hs_pipe_d[0] = hs_raw;
      vs_pipe_d[0] = vs_raw;
      de_pipe_d[0] = de_q;
      for (int i = 1; i < PIPE; i++) begin
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
        de_pipe_d[i] = de_pipe_q[i-1];
      end
      // Gate with the de entering the last stage so colour lines up with blank_o.
      if (de_pipe_d[PIPE-1]) begin
        {red_d, green_d, blue_d} = rgb_i;
      end else begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      run_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      de_q      <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      de_pipe_q <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      run_q     <= run_d;
      x_q       <= x_d;
      y_q       <= y_d;
      de_q      <= de_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      de_pipe_q <= de_pipe_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign fetch_de_o  = de_q;
  assign sof_o       = sof_q;
  assign eol_o       = eol_q;
  assign vga_red_o   = red_q;
  assign vga_green_o = green_q;
  assign vga_blue_o  = blue_q;
  assign horiz_sync  = hs_pipe_q[PIPE-1] ? HS_ACT : ~HS_ACT;
  assign vert_sync   = vs_pipe_q[PIPE-1] ? VS_ACT : ~VS_ACT;
  assign blank_o     = ~de_pipe_q[PIPE-1];

endmodule
